// File: rtl/snake_pkg.sv
`default_nettype none
// ============================================================================
// Module      : snake_pkg
// Description : Shared status codes, VGA 640x480 timing constants, colours
//               and small helpers for the snake display pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
package snake_pkg;

  // Per-pixel status returned by the snake logic
  typedef enum logic [1:0] {
    ST_NONE = 2'b00,
    ST_HEAD = 2'b01,
    ST_BODY = 2'b10,
    ST_WALL = 2'b11
  } status_e;

  // Game status driven by the game controller
  typedef enum logic [1:0] {
    GS_RESTART = 2'b00,
    GS_START   = 2'b01,
    GS_PLAY    = 2'b10,
    GS_DIE     = 2'b11
  } game_status_e;

  // die_flash blink controller states
  typedef enum logic [0:0] {
    FL_SHOW  = 1'b0,
    FL_BLINK = 1'b1
  } flash_state_e;

  // Horizontal timing in pixels
  localparam int H_VIS   = 640;
  localparam int H_FP    = 16;
  localparam int H_SYNC  = 96;
  localparam int H_BP    = 48;
  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;

  // Vertical timing in lines
  localparam int V_VIS   = 480;
  localparam int V_FP    = 10;
  localparam int V_SYNC  = 2;
  localparam int V_BP    = 33;
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

  // 12-bit {R,G,B} colours
  localparam logic [11:0] COL_BLACK = 12'h000;
  localparam logic [11:0] COL_WALL  = 12'h00F;
  localparam logic [11:0] COL_HEAD  = 12'hFF0;
  localparam logic [11:0] COL_BODY  = 12'h0F0;
  localparam logic [11:0] COL_APPLE = 12'hF00;

  // Inclusive range test used for the sync pulse windows
  function automatic logic in_range(input logic [9:0] v, input int lo, input int hi);
    return (int'(v) >= lo) && (int'(v) <= hi);
  endfunction

endpackage
`default_nettype wire

// File: rtl/vga_timing_counter.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_counter
// Description : Pixel-tick divider and 800x525 raster counters. Produces the
//               pixel tick and the one-cycle frame wrap pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_counter
  import snake_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  output logic       tick,
  output logic [9:0] x_pos,
  output logic [9:0] y_pos,
  output logic       frame_start
);

  localparam int                 c_DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(CLK_DIV - 1);
  localparam logic [9:0]         c_X_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]         c_Y_LAST   = 10'(V_TOTAL - 1);

  logic [c_DIV_W-1:0] r_div_cnt;
  logic [9:0]         r_x_pos;
  logic [9:0]         r_y_pos;

  // With CLK_DIV=1 the divider is pinned at 0, so every cycle is a tick
  assign tick = (r_div_cnt == c_DIV_LAST);

  // Clock divider: free-running 0..CLK_DIV-1
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_div_cnt <= '0;
    end else if (tick) begin
      r_div_cnt <= '0;
    end else begin
      r_div_cnt <= r_div_cnt + 1'b1;
    end
  end

  // Raster counters: x wraps at end of line and carries into y
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_x_pos <= '0;
      r_y_pos <= '0;
    end else if (tick) begin
      if (r_x_pos == c_X_LAST) begin
        r_x_pos <= '0;
        r_y_pos <= (r_y_pos == c_Y_LAST) ? 10'd0 : r_y_pos + 10'd1;
      end else begin
        r_x_pos <= r_x_pos + 10'd1;
      end
    end
  end

  assign x_pos       = r_x_pos;
  assign y_pos       = r_y_pos;
  assign frame_start = tick && (r_x_pos == c_X_LAST) && (r_y_pos == c_Y_LAST);

endmodule
`default_nettype wire

// File: rtl/snake_vga_scan.sv
`default_nettype none
// ============================================================================
// Module      : snake_vga_scan
// Description : VGA raster scanner and pixel renderer for the snake display.
//               Registers sync and colour one pixel behind the counters and
//               generates the die_flash blink used during game over.
// Revision    : 1.0 - initial release
// ============================================================================
module snake_vga_scan
  import snake_pkg::*;
#(
  parameter int CLK_DIV      = 4,
  parameter int FLASH_FRAMES = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] snake,
  input  logic       apple,
  input  logic [1:0] game_status,
  output logic [9:0] x_pos,
  output logic [9:0] y_pos,
  output logic       hsync,
  output logic       vsync,
  output logic [3:0] vga_r,
  output logic [3:0] vga_g,
  output logic [3:0] vga_b,
  output logic       die_flash,
  output logic       frame_start
);

  localparam int                c_FC_W    = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;
  localparam logic [c_FC_W-1:0] c_FC_LAST = c_FC_W'(FLASH_FRAMES - 1);

  logic        w_tick;
  logic        w_vis;
  logic        w_hsync;
  logic        w_vsync;
  logic [11:0] w_rgb;
  logic        r_hsync;
  logic        r_vsync;
  logic [11:0] r_rgb;

  flash_state_e      r_state;
  flash_state_e      w_state_nxt;
  logic [c_FC_W-1:0] r_flash_cnt;
  logic [c_FC_W-1:0] w_flash_cnt_nxt;
  logic              r_die_flash;
  logic              w_die_flash_nxt;

  vga_timing_counter #(
    .CLK_DIV(CLK_DIV)
  ) u_timing (
    .clk        (clk),
    .rst        (rst),
    .tick       (w_tick),
    .x_pos      (x_pos),
    .y_pos      (y_pos),
    .frame_start(frame_start)
  );

  assign w_vis   = (x_pos < 10'(H_VIS)) && (y_pos < 10'(V_VIS));
  assign w_hsync = !in_range(x_pos, H_VIS + H_FP, H_VIS + H_FP + H_SYNC - 1);
  assign w_vsync = !in_range(y_pos, V_VIS + V_FP, V_VIS + V_FP + V_SYNC - 1);

  // Pixel colour for the current counter position, first match wins
  always_comb begin
    w_rgb = COL_BLACK;
    if (!w_vis)                w_rgb = COL_BLACK;
    else if (snake == ST_WALL) w_rgb = COL_WALL;
    else if (snake == ST_HEAD) w_rgb = COL_HEAD;
    else if (snake == ST_BODY) w_rgb = COL_BODY;
    else if (apple)            w_rgb = COL_APPLE;
  end

  // Render register: sync and colour for the pixel sampled on this tick
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hsync <= 1'b1;
      r_vsync <= 1'b1;
      r_rgb   <= COL_BLACK;
    end else if (w_tick) begin
      r_hsync <= w_hsync;
      r_vsync <= w_vsync;
      r_rgb   <= w_rgb;
    end
  end

  assign hsync                 = r_hsync;
  assign vsync                 = r_vsync;
  assign {vga_r, vga_g, vga_b} = r_rgb;

  // Flash controller state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= FL_SHOW;
      r_flash_cnt <= '0;
      r_die_flash <= 1'b1;
    end else begin
      r_state     <= w_state_nxt;
      r_flash_cnt <= w_flash_cnt_nxt;
      r_die_flash <= w_die_flash_nxt;
    end
  end

  // Flash controller next state: count frames while dead, toggle on the last
  always_comb begin
    w_state_nxt     = r_state;
    w_flash_cnt_nxt = r_flash_cnt;
    w_die_flash_nxt = r_die_flash;
    if (game_status != GS_DIE) begin
      w_state_nxt     = FL_SHOW;
      w_flash_cnt_nxt = '0;
      w_die_flash_nxt = 1'b1;
    end else begin
      w_state_nxt = FL_BLINK;
      if (frame_start) begin
        if (r_flash_cnt == c_FC_LAST) begin
          w_flash_cnt_nxt = '0;
          w_die_flash_nxt = !r_die_flash;
        end else begin
          w_flash_cnt_nxt = r_flash_cnt + 1'b1;
        end
      end
    end
  end

  assign die_flash = r_die_flash;

endmodule
`default_nettype wire

// File: tb/tb_snake_vga_scan.sv
`default_nettype none
// ============================================================================
// Module      : tb_snake_vga_scan
// Description : Directed self-checking bench for snake_vga_scan. One instance
//               at CLK_DIV=1/FLASH_FRAMES=2, one at CLK_DIV=4.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_snake_vga_scan;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst1, rst4;
  logic [1:0] snake1, game1;
  logic       apple1;
  logic [9:0] x1, y1, x4, y4;
  logic       hs1, vs1, df1, fs1, hs4, vs4, df4, fs4;
  logic [3:0] r1, g1, b1, r4, g4, b4;
  logic [11:0] rgb1, rgb4;

  logic [9:0] tgt_x;
  logic [1:0] tgt_snake;
  logic       tgt_apple;

  // snake/apple respond combinationally to the target column
  assign snake1 = (x1 == tgt_x) ? tgt_snake : 2'b00;
  assign apple1 = (x1 == tgt_x) ? tgt_apple : 1'b0;
  assign rgb1   = {r1, g1, b1};
  assign rgb4   = {r4, g4, b4};

  snake_vga_scan #(.CLK_DIV(1), .FLASH_FRAMES(2)) dut1 (
    .clk(clk), .rst(rst1), .snake(snake1), .apple(apple1), .game_status(game1),
    .x_pos(x1), .y_pos(y1), .hsync(hs1), .vsync(vs1),
    .vga_r(r1), .vga_g(g1), .vga_b(b1), .die_flash(df1), .frame_start(fs1)
  );

  snake_vga_scan #(.CLK_DIV(4), .FLASH_FRAMES(15)) dut4 (
    .clk(clk), .rst(rst4), .snake(2'b00), .apple(1'b0), .game_status(2'b00),
    .x_pos(x4), .y_pos(y4), .hsync(hs4), .vsync(vs4),
    .vga_r(r4), .vga_g(g4), .vga_b(b4), .die_flash(df4), .frame_start(fs4)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_val(input string tag, input int unsigned obs, input int unsigned exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic wait_x1(input logic [9:0] tx);
    bit found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      @(negedge clk);
      if (x1 == tx) found = 1'b1;
    end
    if (!found) check_val("wait_x1_timeout", 0, 1);
  endtask

  task automatic wait_x4(input logic [9:0] tx);
    bit found = 1'b0;
    for (int i = 0; i < 4000 && !found; i++) begin
      @(negedge clk);
      if (x4 == tx) found = 1'b1;
    end
    if (!found) check_val("wait_x4_timeout", 0, 1);
  endtask

  // Target one pixel, expect its colour one tick later and black after it
  task automatic render_case(input string tag, input logic [9:0] tx, input logic [1:0] sn,
                             input logic ap, input logic [11:0] exp);
    tgt_x = tx; tgt_snake = sn; tgt_apple = ap;
    wait_x1(tx);
    @(negedge clk);
    check_val(tag, rgb1, exp);
    @(negedge clk);
    check_val({tag, "_next"}, rgb1, 12'h000);
    tgt_snake = 2'b00; tgt_apple = 1'b0;
  endtask

  task automatic fs_pulse();
    force dut1.frame_start = 1'b1;
    @(negedge clk);
    release dut1.frame_start;
  endtask

  initial begin
    int lows;
    tgt_x = 10'd1023; tgt_snake = 2'b00; tgt_apple = 1'b0;
    game1 = 2'b10;
    rst1 = 1'b0; rst4 = 1'b0;
    repeat (2) @(negedge clk);

    // Reset values
    check_val("rst_x", x1, 0);
    check_val("rst_y", y1, 0);
    check_val("rst_hsync", hs1, 1);
    check_val("rst_vsync", vs1, 1);
    check_val("rst_rgb", rgb1, 0);
    check_val("rst_die_flash", df1, 1);
    check_val("rst_frame_start", fs1, 0);
    check_val("rst_x4", x4, 0);

    // Release both; CLK_DIV=1 advances every cycle, CLK_DIV=4 every fourth
    rst1 = 1'b1; rst4 = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      if (i == 3) check_val("div4_x_hold", x4, 0);
      if (i == 4) check_val("div4_x_step", x4, 1);
    end
    check_val("start_x5", x1, 5);
    check_val("start_y0", y1, 0);

    // hsync window over a full line
    wait_x1(10'd656);
    check_val("hs_before", hs1, 1);
    lows = 0;
    for (int i = 1; i <= 800; i++) begin
      @(negedge clk);
      if (hs1 == 1'b0) lows++;
      if (i == 1)  check_val("hs_fall", hs1, 0);
      if (i == 96) check_val("hs_last_low", hs1, 0);
      if (i == 97) check_val("hs_rise", hs1, 1);
    end
    check_val("hs_low_count", lows, 96);
    check_val("line_period_x", x1, 656);
    check_val("line_period_y", y1, 1);
    check_val("no_frame_start", fs1, 0);

    // Colour priority and visibility
    render_case("wall_offscreen", 10'd700, 2'b11, 1'b0, 12'h000);
    render_case("head", 10'd100, 2'b01, 1'b0, 12'hFF0);
    render_case("apple", 10'd200, 2'b00, 1'b1, 12'hF00);
    render_case("body_over_apple", 10'd300, 2'b10, 1'b1, 12'h0F0);
    render_case("wall_over_apple", 10'd400, 2'b11, 1'b1, 12'h00F);
    render_case("last_visible", 10'd639, 2'b01, 1'b0, 12'hFF0);

    // Mid-line asynchronous reset on the CLK_DIV=4 instance
    wait_x4(10'd300);
    rst4 = 1'b0;
    #1;
    check_val("div4_rst_x", x4, 0);
    check_val("div4_rst_hsync", hs4, 1);
    @(negedge clk);
    rst4 = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      if (i == 3) check_val("div4_restart_hold", x4, 0);
      if (i == 4) check_val("div4_restart_step", x4, 1);
    end

    // vsync window, reached by overriding the line number
    force dut1.y_pos = 10'd489;
    @(negedge clk);
    check_val("vs_489", vs1, 1);
    force dut1.y_pos = 10'd490;
    @(negedge clk);
    check_val("vs_490", vs1, 0);
    force dut1.y_pos = 10'd491;
    @(negedge clk);
    check_val("vs_491", vs1, 0);
    force dut1.y_pos = 10'd492;
    @(negedge clk);
    check_val("vs_492", vs1, 1);
    release dut1.y_pos;

    // Asynchronous reset restores the raster
    rst1 = 1'b0;
    #1;
    check_val("rst1_async_x", x1, 0);
    check_val("rst1_async_y", y1, 0);
    check_val("rst1_async_vsync", vs1, 1);
    @(negedge clk);
    rst1 = 1'b1;

    // die_flash with FLASH_FRAMES=2: 1,0,0,1 after successive frames
    game1 = 2'b11;
    @(negedge clk);
    check_val("die_entry", df1, 1);
    fs_pulse(); check_val("die_f1", df1, 1);
    fs_pulse(); check_val("die_f2", df1, 0);
    fs_pulse(); check_val("die_f3", df1, 0);
    fs_pulse(); check_val("die_f4", df1, 1);
    fs_pulse(); check_val("die_f5", df1, 1);
    fs_pulse(); check_val("die_f6", df1, 0);
    game1 = 2'b10;
    @(negedge clk);
    check_val("play_forces_show", df1, 1);
    fs_pulse(); check_val("play_ignores_frames", df1, 1);
    fs_pulse(); check_val("play_ignores_frames2", df1, 1);
    game1 = 2'b11;
    fs_pulse(); check_val("redie_f1", df1, 1);
    fs_pulse(); check_val("redie_f2", df1, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
